// File: rtl/sprite_layer_mixer_pkg.sv
// Shared video definitions: RGB332 field layout, black constant and the
// helper that sizes the screen-mode select.
package sprite_layer_mixer_pkg;

   localparam int RED_W   = 3;
   localparam int GREEN_W = 3;
   localparam int BLUE_W  = 2;
   localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;
   localparam int POS_W   = 10;

   localparam logic [RGB_W-1:0] COLOR_BLACK = '0;

   typedef struct packed {
      logic [RED_W-1:0]   red;
      logic [GREEN_W-1:0] green;
      logic [BLUE_W-1:0]  blue;
   } rgb332_t;

   // A single mode still needs a one-bit select port.
   function automatic int mode_width(input int num_modes);
      return (num_modes > 1) ? $clog2(num_modes) : 1;
   endfunction

endpackage

// File: rtl/sprite_layer_mixer_layer_priority_select.sv
// Combinational priority picker: reports whether any layer is visible and
// the index of the lowest-numbered visible one.
module layer_priority_select #(
   parameter  int NUM_LAYERS = 8,
   localparam int IDX_W      = $clog2(NUM_LAYERS)
) (
   input  logic [NUM_LAYERS-1:0] visible,
   output logic                  valid,
   output logic [IDX_W-1:0]      index
);

   // NOTE: index gets a default before the loop so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      valid = |visible;
      index = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (visible[i]) index = IDX_W'(i);
      end
   end

endmodule

// File: rtl/sprite_layer_mixer.sv
// Sprite layer mixer: per-pixel priority compositing over a per-mode
// background, frame-latched screen mode and player collision tracking.
module sprite_layer_mixer
   import sprite_layer_mixer_pkg::*;
#(
   parameter  int NUM_LAYERS   = 8,
   parameter  int NUM_MODES    = 4,
   parameter  int PLAYER_LAYER = 0,
   parameter  int H_ACTIVE     = 640,
   parameter  int V_ACTIVE     = 480,
   localparam int MODE_W       = mode_width(NUM_MODES),
   localparam int IDX_W        = $clog2(NUM_LAYERS)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   input  logic [POS_W-1:0]                hcount,
   input  logic [POS_W-1:0]                vcount,
   input  logic [NUM_LAYERS-1:0]           layer_data,
   input  logic [RGB_W*NUM_LAYERS-1:0]     layer_rgb,
   input  logic [MODE_W-1:0]               mode_in,
   input  logic [NUM_MODES*NUM_LAYERS-1:0] mode_layer_mask,
   input  logic [NUM_LAYERS-1:0]           enemy_mask,
   input  logic [RGB_W*NUM_MODES-1:0]      bg_rgb,
   output logic [RED_W-1:0]                red,
   output logic [GREEN_W-1:0]              green,
   output logic [BLUE_W-1:0]               blue,
   output logic [MODE_W-1:0]               active_mode,
   output logic                            frame_start,
   output logic                            collision_pulse,
   output logic                            collision
);

   localparam logic [POS_W-1:0]      H_LIM      = POS_W'(H_ACTIVE);
   localparam logic [POS_W-1:0]      V_LIM      = POS_W'(V_ACTIVE);
   localparam logic [NUM_LAYERS-1:0] PLAYER_BIT = NUM_LAYERS'(1) << PLAYER_LAYER;

   logic                  is_origin;
   logic                  in_active;
   logic [MODE_W-1:0]     mode_eff;
   logic [NUM_LAYERS-1:0] mode_mask;
   logic [NUM_LAYERS-1:0] visible;
   logic [NUM_LAYERS-1:0] enemy_visible;
   logic                  hit;
   logic                  sel_valid;
   logic [IDX_W-1:0]      sel_index;
   rgb332_t               pix_sel;

   rgb332_t           pix_q, pix_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic              sticky_q, sticky_d;
   logic              coll_q, coll_d;
   logic              pulse_q, pulse_d;
   logic              fs_q, fs_d;

   // The origin pixel already belongs to the new frame, so it uses mode_in.
   always_comb begin
      is_origin     = (hcount == '0) && (vcount == '0);
      in_active     = (hcount < H_LIM) && (vcount < V_LIM);
      mode_eff      = is_origin ? mode_in : mode_q;
      mode_mask     = mode_layer_mask[int'(mode_eff)*NUM_LAYERS +: NUM_LAYERS];
      visible       = layer_data & mode_mask;
      enemy_visible = visible & enemy_mask & ~PLAYER_BIT;
      hit           = in_active && visible[PLAYER_LAYER] && (|enemy_visible);
   end

   layer_priority_select #(
      .NUM_LAYERS (NUM_LAYERS)
   ) u_select (
      .visible (visible),
      .valid   (sel_valid),
      .index   (sel_index)
   );

   always_comb begin
      if (!in_active)
         pix_sel = rgb332_t'(COLOR_BLACK);
      else if (sel_valid)
         pix_sel = rgb332_t'(layer_rgb[int'(sel_index)*RGB_W +: RGB_W]);
      else
         pix_sel = rgb332_t'(bg_rgb[int'(mode_eff)*RGB_W +: RGB_W]);
   end

   always_comb begin
      pix_d    = pix_q;
      mode_d   = mode_q;
      sticky_d = sticky_q;
      coll_d   = coll_q;
      pulse_d  = 1'b0;
      fs_d     = 1'b0;
      if (enable) begin
         pix_d  = pix_sel;
         mode_d = mode_eff;
         fs_d   = is_origin;
         // A hit on the origin pixel is the first hit of the new frame.
         if (is_origin) begin
            coll_d   = sticky_q;
            sticky_d = hit;
            pulse_d  = hit;
         end else begin
            sticky_d = sticky_q | hit;
            pulse_d  = hit & ~sticky_q;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         pix_q    <= rgb332_t'(COLOR_BLACK);
         mode_q   <= '0;
         sticky_q <= 1'b0;
         coll_q   <= 1'b0;
         pulse_q  <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         pix_q    <= pix_d;
         mode_q   <= mode_d;
         sticky_q <= sticky_d;
         coll_q   <= coll_d;
         pulse_q  <= pulse_d;
         fs_q     <= fs_d;
      end
   end

   assign red             = pix_q.red;
   assign green           = pix_q.green;
   assign blue            = pix_q.blue;
   assign active_mode     = mode_q;
   assign frame_start     = fs_q;
   assign collision_pulse = pulse_q;
   assign collision       = coll_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Scoreboard bench for sprite_layer_mixer: directed pixels push expected
// registered outputs; a monitor pops and compares one per clock.
module tb_sprite_layer_mixer;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [7:0]  layer_data;
   logic [63:0] layer_rgb;
   logic [1:0]  mode_in;
   logic [31:0] mode_layer_mask;
   logic [7:0]  enemy_mask;
   logic [31:0] bg_rgb;
   logic [2:0]  red;
   logic [2:0]  green;
   logic [1:0]  blue;
   logic [1:0]  active_mode;
   logic        frame_start;
   logic        collision_pulse;
   logic        collision;

   typedef struct {
      logic [7:0] rgb;
      logic [1:0] mode;
      logic       fs;
      logic       pulse;
      logic       coll;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   sprite_layer_mixer dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .hcount          (hcount),
      .vcount          (vcount),
      .layer_data      (layer_data),
      .layer_rgb       (layer_rgb),
      .mode_in         (mode_in),
      .mode_layer_mask (mode_layer_mask),
      .enemy_mask      (enemy_mask),
      .bg_rgb          (bg_rgb),
      .red             (red),
      .green           (green),
      .blue            (blue),
      .active_mode     (active_mode),
      .frame_start     (frame_start),
      .collision_pulse (collision_pulse),
      .collision       (collision)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int step_no,
                        input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s step %0d: got 0x%02h expected 0x%02h",
                  name, step_no, actual, expected);
      end
   endtask

   int step_cnt = 0;

   task automatic step(input logic rst, input logic en, input int h, input int v,
                       input logic [7:0] data, input logic [1:0] mode,
                       input logic [7:0] enemy, input logic [7:0] e_rgb,
                       input logic [1:0] e_mode, input logic e_fs,
                       input logic e_pulse, input logic e_coll);
      exp_t e;
      reset      = rst;
      enable     = en;
      hcount     = 10'(h);
      vcount     = 10'(v);
      layer_data = data;
      mode_in    = mode;
      enemy_mask = enemy;
      e.rgb   = e_rgb;
      e.mode  = e_mode;
      e.fs    = e_fs;
      e.pulse = e_pulse;
      e.coll  = e_coll;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Monitor: the entry queued before this edge is the response to it.
   initial begin
      exp_t e;
      int   n = 0;
      forever begin
         @(posedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clock);
            check("rgb",   n, {red, green, blue}, e.rgb);
            check("mode",  n, {6'd0, active_mode}, {6'd0, e.mode});
            check("fs",    n, {7'd0, frame_start}, {7'd0, e.fs});
            check("pulse", n, {7'd0, collision_pulse}, {7'd0, e.pulse});
            check("coll",  n, {7'd0, collision}, {7'd0, e.coll});
            n++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset           = 1'b1;
      enable          = 1'b0;
      hcount          = '0;
      vcount          = '0;
      layer_data      = '0;
      mode_in         = '0;
      enemy_mask      = '0;
      layer_rgb       = {8'h47, 8'h46, 8'h1C, 8'h44, 8'h90, 8'hE0, 8'h41, 8'h03};
      mode_layer_mask = {8'hFB, 8'hFF, 8'hFF, 8'hFF};
      bg_rgb          = {8'h33, 8'h49, 8'h22, 8'h11};
      @(posedge clock);
      #1;

      //    rst  en   h    v    data   mi  enemy   rgb    mode fs pl co
      // reset overrides an enabled origin pixel with a hit
      step(1, 1,   0,   0, 8'h09, 3, 8'h08, 8'h00, 0, 0, 0, 0);
      step(1, 1,   0,   0, 8'h09, 3, 8'h08, 8'h00, 0, 0, 0, 0);
      // partial frame after reset runs in mode 0
      step(0, 1, 100, 100, 8'h24, 2, 8'h00, 8'hE0, 0, 0, 0, 0);
      step(0, 0, 101, 100, 8'h00, 2, 8'h00, 8'hE0, 0, 0, 0, 0);
      step(0, 1, 700, 100, 8'h24, 2, 8'h00, 8'h00, 0, 0, 0, 0);
      // frame in mode 2: background and active-area edges
      step(0, 1,   0,   0, 8'h00, 2, 8'h00, 8'h49, 2, 1, 0, 0);
      step(0, 1, 300, 200, 8'h00, 2, 8'h00, 8'h49, 2, 0, 0, 0);
      step(0, 1, 650, 200, 8'h00, 2, 8'h00, 8'h00, 2, 0, 0, 0);
      step(0, 1, 300, 480, 8'h24, 2, 8'h00, 8'h00, 2, 0, 0, 0);
      step(0, 1, 639, 479, 8'h24, 2, 8'h00, 8'hE0, 2, 0, 0, 0);
      // mode 1 frame with a mid-frame request for mode 3
      step(0, 1,   0,   0, 8'h00, 1, 8'h00, 8'h22, 1, 1, 0, 0);
      step(0, 1, 320, 240, 8'h24, 3, 8'h00, 8'hE0, 1, 0, 0, 0);
      step(0, 1, 321, 240, 8'h00, 3, 8'h00, 8'h22, 1, 0, 0, 0);
      // mode 3 hides layer 2, so layer 5 wins
      step(0, 1,   0,   0, 8'h24, 3, 8'h08, 8'h1C, 3, 1, 0, 0);
      // two hits in one frame: single pulse
      step(0, 1,  10,  10, 8'h09, 3, 8'h08, 8'h03, 3, 0, 1, 0);
      step(0, 1,  11,  10, 8'h09, 3, 8'h08, 8'h03, 3, 0, 0, 0);
      step(0, 1,   0,   0, 8'h00, 3, 8'h08, 8'h33, 3, 1, 0, 1);
      // self collision ignored, off-screen hit ignored, no enemy no hit
      step(0, 1,   5,   5, 8'h01, 3, 8'hFF, 8'h03, 3, 0, 0, 1);
      step(0, 1, 700,   5, 8'h09, 3, 8'h08, 8'h00, 3, 0, 0, 1);
      step(0, 1,   5,   5, 8'h09, 3, 8'h00, 8'h03, 3, 0, 0, 1);
      // hit exactly on the origin pixel belongs to the new frame
      step(0, 1,   0,   0, 8'h09, 3, 8'h08, 8'h03, 3, 1, 1, 0);
      step(0, 1,   1,   0, 8'h09, 3, 8'h08, 8'h03, 3, 0, 0, 0);
      step(0, 1,   0,   0, 8'h00, 3, 8'h08, 8'h33, 3, 1, 0, 1);
      step(0, 1,   0,   1, 8'h09, 3, 8'h08, 8'h03, 3, 0, 1, 1);
      // mid-frame reset while collision is high
      step(1, 1,   5,   5, 8'h09, 3, 8'h08, 8'h00, 0, 0, 0, 0);
      step(0, 1,   6,   5, 8'h24, 2, 8'h08, 8'hE0, 0, 0, 0, 0);
      step(0, 1,   7,   5, 8'h09, 2, 8'h08, 8'h03, 0, 0, 1, 0);
      step(0, 1,   0,   0, 8'h00, 2, 8'h08, 8'h49, 2, 1, 0, 1);
      // disabled origin: no frame_start, everything holds
      step(0, 0,   0,   0, 8'h09, 1, 8'h08, 8'h49, 2, 0, 0, 1);

      @(negedge clock);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_layer_mixer.md
SPRITE_LAYER_MIXER -- requirements
Module: sprite_layer_mixer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8: number of sprite layers, range 2..16.
REQ-002 SHALL have parameter NUM_MODES, default 4: number of screen modes, a power of two.
REQ-003 SHALL have parameter PLAYER_LAYER, default 0: index of the layer tested for collision.
REQ-004 SHALL have parameters H_ACTIVE, default 640, and V_ACTIVE, default 480: visible area in pixels.
REQ-005 SHALL have port clock, input, 1: single clock for the block.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port enable, input, 1: pixel strobe; all state advances only when it is high.
REQ-008 SHALL have ports hcount and vcount, input, 10 each: current pixel position.
REQ-009 SHALL have port layer_data, input, NUM_LAYERS: per-layer opaque-pixel flag.
REQ-010 SHALL have port layer_rgb, input, 8*NUM_LAYERS: per-layer colour, RGB 3/3/2; layer i occupies bits [8i+7:8i].
REQ-011 SHALL have port mode_in, input, log2(NUM_MODES): requested screen mode.
REQ-012 SHALL have port mode_layer_mask, input, NUM_MODES*NUM_LAYERS: visibility of each layer in each mode.
REQ-013 SHALL have port enemy_mask, input, NUM_LAYERS: layers that collide with PLAYER_LAYER.
REQ-014 SHALL have port bg_rgb, input, 8*NUM_MODES: background colour for each mode.
REQ-015 SHALL have ports red [2:0], green [2:0] and blue [1:0], output: registered pixel colour.
REQ-016 SHALL have port active_mode, output, log2(NUM_MODES): mode in force for the current frame.
REQ-017 SHALL have ports frame_start, collision_pulse and collision, output, 1 each.

Function
REQ-018 SHALL assert frame_start for exactly one clock on any enable cycle where hcount==0 and vcount==0.
REQ-019 SHALL load active_mode from mode_in only on frame_start cycles; mode_in changes mid-frame SHALL NOT take effect until the next frame.
REQ-020 SHALL treat layer i as visible when layer_data[i] and mode_layer_mask[active_mode*NUM_LAYERS+i] are both 1.
REQ-021 SHALL, in the active area (hcount<H_ACTIVE, vcount<V_ACTIVE), output the colour of the lowest-index visible layer, or bg_rgb[active_mode] when no layer is visible.
REQ-022 SHALL output colour 0 outside the active area.
REQ-023 SHALL register colour with latency of one enable cycle and SHALL hold red, green and blue while enable is low.
REQ-024 SHALL detect a hit when, in the active area, PLAYER_LAYER is visible and any layer j with enemy_mask[j]=1, j!=PLAYER_LAYER, is visible.
REQ-025 SHALL set a per-frame sticky flag on a hit, and SHALL pulse collision_pulse for one clock on the first hit of each frame only.
REQ-026 SHALL, on frame_start, copy the sticky flag to collision (held for the whole next frame) and clear the sticky flag.
REQ-027 SHALL, when frame_start and a hit coincide, count the hit in the new frame: the sticky flag SHALL end at 1 and collision_pulse SHALL fire.
REQ-028 SHALL ignore enemy_mask[PLAYER_LAYER]; a layer SHALL never collide with itself.

Reset
REQ-029 SHALL, on reset, drive red, green, blue, active_mode, collision, collision_pulse, frame_start and the sticky flag to 0, overriding enable.
REQ-030 SHALL resume from the first frame_start after reset is released; a partial frame SHALL use mode 0.

Structure
REQ-031 SHALL place the RGB332 field widths, the colour-black constant and the mode width function in the shared video package.
REQ-032 SHALL implement priority selection as the combinational sub-module layer_priority_select, parametrised by NUM_LAYERS, with outputs valid and index.

Verification
REQ-033 SHALL be verified with NUM_LAYERS=8, layers 2 and 5 visible with colours 0xE0 and 0x1C at (100,100) -> colour 0xE0 one enable cycle later.
REQ-034 SHALL be verified with no layer visible, active_mode=2 and bg_rgb[2]=0x49 at (300,200) -> colour 0x49; the same stimulus at (650,200) -> colour 0x00.
REQ-035 SHALL be verified with mode_in switched from 1 to 3 at (320,240) -> active_mode stays 1 until the next (0,0), then becomes 3.
REQ-036 SHALL be verified with layers 0 and 3 visible, enemy_mask=0x08, at (10,10) and again at (11,10) -> one collision_pulse only; collision=1 after the next frame_start and 0 after the following one.
REQ-037 SHALL be verified with a hit at exactly (0,0) -> frame_start and collision_pulse in the same cycle, and collision=1 one frame later.
REQ-038 SHALL be verified with reset asserted mid-frame while collision=1 -> all outputs 0 on the next clock.
